reg_write_buffer: RTL and testbench

REG_WRITE_BUFFER -- requirements
Module: reg_write_buffer

---
 rtl/reg_write_buffer_if.sv | 31 +++
 rtl/reg_write_buffer.sv | 78 +++++++
 tb/tb_reg_write_buffer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_buffer_if.sv
// Register write buffer bus: producer push, register-file write port,
// read-stage lookup probe and occupancy.
interface reg_write_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              inValid;
    logic [4:0]        inAddr;
    logic [DATA_W-1:0] inData;
    logic              inReady;
    logic              stall;
    logic              regWrite;
    logic [4:0]        writeAddr;
    logic [DATA_W-1:0] writeData;
    logic [4:0]        lookupAddr;
    logic              lookupHit;
    logic [DATA_W-1:0] lookupData;
    logic [CNT_W-1:0]  count;

    modport master (
        output inValid, inAddr, inData, stall, lookupAddr,
        input  inReady, regWrite, writeAddr, writeData, lookupHit, lookupData, count
    );

    modport slave (
        input  inValid, inAddr, inData, stall, lookupAddr,
        output inReady, regWrite, writeAddr, writeData, lookupHit, lookupData, count
    );
endinterface

// File: rtl/reg_write_buffer.sv
// Circular FIFO of pending register writes in front of the register file,
// with in-order drain and youngest-match forwarding to the read stage.
module reg_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    reg_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [4:0]        addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              not_empty;
    logic              push;
    logic              pop;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  idx;

    // Ready depends on registered occupancy only: a full buffer refuses
    // even in a cycle where it drains.
    assign not_empty     = (count_q != '0);
    assign bus.inReady   = (count_q != FULL);
    assign push          = bus.inValid && bus.inReady;
    assign pop           = not_empty && !bus.stall;

    assign bus.regWrite  = pop;
    assign bus.writeAddr = not_empty ? addr_mem[head] : '0;
    assign bus.writeData = not_empty ? data_mem[head] : '0;
    assign bus.count     = count_q;
    assign bus.lookupHit  = hit;
    assign bus.lookupData = hit_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage is never reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= bus.inAddr;
            data_mem[tail] <= bus.inData;
        end
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem[idx] == bus.lookupAddr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed bench for reg_write_buffer; expected writes go into a scoreboard
// queue that a negedge monitor pops whenever the write strobe is seen.
module tb_reg_write_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    reg_write_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    reg_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input bit accept);
        wr_t e;
        bus.inValid = 1'b1;
        bus.inAddr  = a;
        bus.inData  = d;
        tick();
        bus.inValid = 1'b0;
        if (accept) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every strobed write must be the oldest outstanding expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.regWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                             bus.writeAddr, bus.writeData);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(bus.writeAddr), 32'(e.addr));
                    check("write_data", bus.writeData, e.data);
                end
            end
        end
    end

    initial begin
        int  mc;
        int  i;
        int  cyc;
        bit  acc;
        bit  pp;
        wr_t e;

        rst            = 1'b0;
        bus.inValid    = 1'b0;
        bus.inAddr     = '0;
        bus.inData     = '0;
        bus.stall      = 1'b0;
        bus.lookupAddr = '0;

        #3;
        check("rst_in_ready",    32'(bus.inReady),    1);
        check("rst_reg_write",   32'(bus.regWrite),   0);
        check("rst_write_addr",  32'(bus.writeAddr),  0);
        check("rst_write_data",  bus.writeData,       0);
        check("rst_lookup_hit",  32'(bus.lookupHit),  0);
        check("rst_lookup_data", bus.lookupData,      0);
        check("rst_count",       32'(bus.count),      0);
        #9 rst = 1'b1;
        tick();

        // Single write drains the cycle after acceptance.
        push(5'd5, 32'd64, 1'b1);
        check("single_strobe", 32'(bus.regWrite), 1);
        tick();
        check("single_count_after", 32'(bus.count), 0);
        check("single_strobe_after", 32'(bus.regWrite), 0);

        // Fill under stall, reject a fifth, then drain back to back.
        bus.stall = 1'b1;
        for (int k = 1; k <= 4; k++) push(5'(k), 32'(10 * k), 1'b1);
        check("full_count", 32'(bus.count), 4);
        check("full_in_ready", 32'(bus.inReady), 0);
        check("full_stall_strobe", 32'(bus.regWrite), 0);
        push(5'd5, 32'd50, 1'b0);
        check("full_count_after_reject", 32'(bus.count), 4);
        bus.lookupAddr = 5'd3;
        #1;
        check("full_lookup_hit", 32'(bus.lookupHit), 1);
        check("full_lookup_data", bus.lookupData, 30);
        bus.stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_consecutive", 32'(bus.regWrite), 1);
            tick();
        end
        check("drain_empty_count", 32'(bus.count), 0);
        check("drain_empty_strobe", 32'(bus.regWrite), 0);

        // Forwarding: youngest duplicate wins; accepting entry is invisible.
        bus.stall      = 1'b1;
        bus.lookupAddr = 5'd12;
        bus.inValid    = 1'b1;
        bus.inAddr     = 5'd12;
        bus.inData     = 32'd15;
        #1;
        check("fwd_accepting_invisible", 32'(bus.lookupHit), 0);
        tick();
        bus.inValid = 1'b0;
        e.addr = 5'd12;
        e.data = 32'd15;
        exp_q.push_back(e);
        push(5'd12, 32'd99, 1'b1);
        check("fwd_hit", 32'(bus.lookupHit), 1);
        check("fwd_data_youngest", bus.lookupData, 99);
        bus.lookupAddr = 5'd31;
        #1;
        check("fwd_miss_hit", 32'(bus.lookupHit), 0);
        check("fwd_miss_data", bus.lookupData, 0);
        bus.lookupAddr = 5'd12;
        bus.stall      = 1'b0;
        #1;
        check("fwd_hit_while_popping", 32'(bus.lookupHit), 1);
        check("fwd_data_while_popping", bus.lookupData, 99);
        tick();
        tick();
        check("fwd_drained", 32'(bus.count), 0);

        // Wrap-around with alternating stall, tracked by an occupancy model.
        mc  = 0;
        i   = 0;
        cyc = 0;
        while (i < 10 && cyc < 60) begin
            bus.stall   = (cyc % 2 == 1);
            bus.inValid = 1'b1;
            bus.inAddr  = 5'(i);
            bus.inData  = 32'(100 + i);
            acc = (mc != DEPTH);
            pp  = (mc != 0) && !bus.stall;
            tick();
            if (acc) begin
                e.addr = 5'(i);
                e.data = 32'(100 + i);
                exp_q.push_back(e);
                i++;
            end
            mc = mc + int'(acc) - int'(pp);
            check("wrap_count", 32'(bus.count), 32'(mc));
            check("wrap_bound", 32'(bus.count <= 4), 1);
            cyc++;
        end
        bus.inValid = 1'b0;
        bus.stall   = 1'b0;
        check("wrap_all_accepted", 32'(i), 10);
        repeat (4) tick();
        check("wrap_drained", 32'(bus.count), 0);

        // Simultaneous push and pop at count 2.
        bus.stall = 1'b1;
        push(5'd7, 32'd70, 1'b1);
        push(5'd8, 32'd80, 1'b1);
        check("simul_pre_count", 32'(bus.count), 2);
        bus.stall = 1'b0;
        push(5'd9, 32'd90, 1'b1);
        check("simul_count", 32'(bus.count), 2);
        tick();
        tick();
        check("simul_drained", 32'(bus.count), 0);

        // Async reset between edges discards pending entries.
        bus.stall = 1'b1;
        push(5'd20, 32'd1, 1'b1);
        push(5'd21, 32'd2, 1'b1);
        push(5'd22, 32'd3, 1'b1);
        check("areset_pre_count", 32'(bus.count), 3);
        bus.lookupAddr = 5'd21;
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("areset_count", 32'(bus.count), 0);
        check("areset_strobe", 32'(bus.regWrite), 0);
        check("areset_in_ready", 32'(bus.inReady), 1);
        check("areset_lookup_hit", 32'(bus.lookupHit), 0);
        @(negedge clk);
        rst       = 1'b1;
        bus.stall = 1'b0;
        repeat (3) tick();
        check("areset_no_write", 32'(bus.regWrite), 0);
        check("areset_count_after", 32'(bus.count), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
